wb_fetch_linebuf: RTL and testbench

- Single-line, critical-word-first instruction fetch buffer between the CPU instruction port and the boot ROM / Wishbone B3 slave.
- Hits on the buffered 4-word line are served locally.
- A miss issues one wrap-4 incrementing burst (cti=010, bte=01) starting at the requested word.
- The block is the Wishbone master directly upstream of the burst-capable ROM slave.

---
 rtl/wb_fetch_linebuf_if.sv | 47 ++++
 rtl/wb_fetch_linebuf.sv | 205 ++++++++++++++++++++
 tb/tb_wb_fetch_linebuf.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_fetch_linebuf_if.sv
// ----------------------------------------------------------------------------
// wb_fetch_linebuf_if
//
// Wishbone B3 read-only burst bus between the fetch line buffer (master) and
// the boot ROM slave.
//
// Signals (master view):
//   adr  out  ADDR_WIDTH-2  word address            (wbm_adr_o)
//   cyc  out  1             bus cycle               (wbm_cyc_o)
//   stb  out  1             strobe                  (wbm_stb_o)
//   cti  out  3             cycle type identifier   (wbm_cti_o)
//   bte  out  2             burst type extension    (wbm_bte_o)
//   dat  in   32            read data               (wbm_dat_i)
//   ack  in   1             slave acknowledge       (wbm_ack_i)
//   err  in   1             slave error, only when WB_FETCH_ERR_EN is defined
//                                                   (wbm_err_i)
// ----------------------------------------------------------------------------
interface wb_fetch_linebuf_if #(
    parameter int ADDR_WIDTH = 24
);
    logic [ADDR_WIDTH-3:0] adr;
    logic                  cyc;
    logic                  stb;
    logic [2:0]            cti;
    logic [1:0]            bte;
    logic [31:0]           dat;
    logic                  ack;
`ifdef WB_FETCH_ERR_EN
    logic                  err;
`endif

    modport master (
        output adr, cyc, stb, cti, bte,
`ifdef WB_FETCH_ERR_EN
        input  err,
`endif
        input  dat, ack
    );

    modport slave (
        input  adr, cyc, stb, cti, bte,
`ifdef WB_FETCH_ERR_EN
        output err,
`endif
        output dat, ack
    );
endinterface

// File: rtl/wb_fetch_linebuf.sv
// ----------------------------------------------------------------------------
// wb_fetch_linebuf
//
// Single-line (4 x 32-bit word) critical-word-first instruction fetch buffer.
// Hits on the buffered line are answered one cycle after the request. A miss
// starts one wrap-4 incrementing Wishbone burst (cti=010, bte=01) at the
// requested word; the CPU is acked the cycle after that word's beat.
//
// Parameters:
//   ADDR_WIDTH  byte-address width (minimum 5); all address ports carry word
//               addresses [ADDR_WIDTH-1:2].
//
// Ports:
//   wb_clk      in   clock
//   wb_rst      in   asynchronous reset, active high
//   cpu_adr_i   in   requested word address
//   cpu_req_i   in   fetch request, held until cpu_ack_o
//   cpu_dat_o   out  fetched instruction (registered)
//   cpu_ack_o   out  one-cycle completion strobe
//   cpu_err_o   out  one-cycle error strobe (WB_FETCH_ERR_EN only)
//   flush_i     in   single-cycle line invalidate
//   wbm         Wishbone master modport (see wb_fetch_linebuf_if)
//
// Build option:
//   WB_FETCH_ERR_EN  adds wbm.err / cpu_err_o; a bus error aborts the burst
//                    and invalidates the line.
// ----------------------------------------------------------------------------
module wb_fetch_linebuf #(
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic [ADDR_WIDTH-3:0] cpu_adr_i,
    input  logic                  cpu_req_i,
    output logic [31:0]           cpu_dat_o,
    output logic                  cpu_ack_o,
`ifdef WB_FETCH_ERR_EN
    output logic                  cpu_err_o,
`endif
    input  logic                  flush_i,
    wb_fetch_linebuf_if.master    wbm
);

    localparam int TAG_W = ADDR_WIDTH - 4;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;

    logic [0:0]       state_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       valid_q;
    logic [31:0]      line_data [4];
    logic [1:0]       beat_q;
    logic             flush_pend_q;   // flush seen mid-burst, applied at burst end

    logic [TAG_W-1:0] cpu_tag;
    logic [1:0]       cpu_word;
    logic             in_burst;
    logic             tag_match;
    logic             line_hit;
    logic             bus_err;
    logic             beat_ack;
    logic             fill_hit;
    logic             serve;
    logic             miss_start;

    assign cpu_tag  = cpu_adr_i[ADDR_WIDTH-3:2];
    assign cpu_word = cpu_adr_i[1:0];

    assign in_burst  = (state_q == S_BURST);
    assign tag_match = (cpu_tag == tag_q);
    assign line_hit  = tag_match && valid_q[cpu_word];

`ifdef WB_FETCH_ERR_EN
    assign bus_err = in_burst && wbm.err;
`else
    assign bus_err = 1'b0;
`endif

    // A beat is only consumed when it carries data; an error beat does not.
    assign beat_ack = in_burst && wbm.ack && !bus_err;

    // The beat landing this cycle is the one the CPU is waiting for: forward
    // it straight into the output register (critical word / in-flight word).
    assign fill_hit = beat_ack && tag_match && (wbm.adr[1:0] == cpu_word);

    // The !cpu_ack_o term keeps ack from ever firing on consecutive cycles
    // and stops the request that was just acked from being re-accepted.
    assign serve      = cpu_req_i && !cpu_ack_o && (line_hit || fill_hit);
    assign miss_start = !in_burst && cpu_req_i && !cpu_ack_o && !line_hit;

`ifdef WB_FETCH_ERR_EN
    logic err_strobe;
    // Only report the error if the word the CPU is waiting on never arrived.
    assign err_strobe = bus_err && cpu_req_i && !cpu_ack_o && tag_match
                        && !valid_q[cpu_word];

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            cpu_err_o <= 1'b0;
        end else begin
            cpu_err_o <= err_strobe;
        end
    end
`endif

    // NOTE: the line storage has no reset; valid_q alone decides whether a
    // word may be used, so clearing the data array would only cost logic.
    always_ff @(posedge wb_clk) begin
        if (beat_ack) begin
            line_data[wbm.adr[1:0]] <= wbm.dat;
        end
    end

    // NOTE: every register here is updated with <= so that all of them see
    // the pre-edge values of state_q, valid_q and wbm.adr in the same cycle.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            valid_q      <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            cpu_ack_o    <= 1'b0;
            cpu_dat_o    <= '0;
            wbm.adr      <= '0;
            wbm.cyc      <= 1'b0;
            wbm.stb      <= 1'b0;
            wbm.cti      <= CTI_CLASSIC;
            wbm.bte      <= BTE_LINEAR;
        end else begin
            cpu_ack_o <= serve;
            if (serve) begin
                cpu_dat_o <= line_hit ? line_data[cpu_word] : wbm.dat;
            end

            case (state_q)
                S_IDLE: begin
                    if (flush_i) begin
                        valid_q <= '0;
                    end
                    if (miss_start) begin
                        state_q      <= S_BURST;
                        tag_q        <= cpu_tag;
                        valid_q      <= '0;
                        beat_q       <= '0;
                        flush_pend_q <= 1'b0;
                        wbm.adr      <= cpu_adr_i;
                        wbm.cyc      <= 1'b1;
                        wbm.stb      <= 1'b1;
                        wbm.cti      <= CTI_INCR;
                        wbm.bte      <= BTE_WRAP4;
                    end
                end

                S_BURST: begin
                    if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end

                    if (bus_err) begin
                        state_q      <= S_IDLE;
                        valid_q      <= '0;
                        flush_pend_q <= 1'b0;
                        wbm.cyc      <= 1'b0;
                        wbm.stb      <= 1'b0;
                        wbm.cti      <= CTI_CLASSIC;
                        wbm.bte      <= BTE_LINEAR;
                    end else if (wbm.ack) begin
                        valid_q[wbm.adr[1:0]] <= 1'b1;
                        // Wrap within the line: only the word bits advance.
                        wbm.adr[1:0] <= wbm.adr[1:0] + 2'd1;
                        beat_q       <= beat_q + 2'd1;

                        if (beat_q == 2'd2) begin
                            wbm.cti <= CTI_EOB;
                        end

                        if (beat_q == 2'd3) begin
                            state_q      <= S_IDLE;
                            flush_pend_q <= 1'b0;
                            wbm.cyc      <= 1'b0;
                            wbm.stb      <= 1'b0;
                            wbm.cti      <= CTI_CLASSIC;
                            wbm.bte      <= BTE_LINEAR;
                            // A flush during the burst wins over the fill.
                            if (flush_pend_q || flush_i) begin
                                valid_q <= '0;
                            end
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_fetch_linebuf.sv
// ----------------------------------------------------------------------------
// tb_wb_fetch_linebuf
//
// Directed bench for wb_fetch_linebuf. A behavioural burst ROM slave answers
// on the Wishbone interface with a programmable number of wait states; its
// content at word address a is 32'hA940_0000 | a. A table of fetch records
// covers hits and misses; hand-written sequences cover the multi-cycle cases
// (critical word, in-flight requests, stall on a foreign line, flush, reset
// mid-burst and, with WB_FETCH_ERR_EN, bus errors).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_fetch_linebuf;

    localparam int AW = 24;
    localparam int WA = AW - 2;

    logic          wb_clk;
    logic          wb_rst;
    logic [WA-1:0] cpu_adr_i;
    logic          cpu_req_i;
    logic [31:0]   cpu_dat_o;
    logic          cpu_ack_o;
    logic          flush_i;
`ifdef WB_FETCH_ERR_EN
    logic          cpu_err_o;
`endif

    wb_fetch_linebuf_if #(.ADDR_WIDTH(AW)) bus ();

    wb_fetch_linebuf #(.ADDR_WIDTH(AW)) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .cpu_adr_i (cpu_adr_i),
        .cpu_req_i (cpu_req_i),
        .cpu_dat_o (cpu_dat_o),
        .cpu_ack_o (cpu_ack_o),
`ifdef WB_FETCH_ERR_EN
        .cpu_err_o (cpu_err_o),
`endif
        .flush_i   (flush_i),
        .wbm       (bus.master)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- ROM slave ----------------
    int   waits    = 0;
    int   err_beat = -1;
    int   wcnt     = 0;
    int   sbeat    = 0;
    logic slv_err  = 1'b0;
`ifdef WB_FETCH_ERR_EN
    assign bus.err = slv_err;
`endif

    function automatic logic [31:0] rom(input logic [WA-1:0] a);
        return 32'hA940_0000 | {10'd0, a};
    endfunction

    initial begin
        bus.ack = 1'b0;
        bus.dat = '0;
    end

    always @(negedge wb_clk) begin
        if (bus.cyc && bus.stb) begin
            if (wcnt >= waits) begin
                wcnt = 0;
                bus.dat = rom(bus.adr);
                if (sbeat == err_beat) begin
                    slv_err = 1'b1;
                    bus.ack = 1'b0;
                end else begin
                    slv_err = 1'b0;
                    bus.ack = 1'b1;
                end
                sbeat++;
            end else begin
                wcnt++;
                bus.ack = 1'b0;
                slv_err = 1'b0;
            end
        end else begin
            bus.ack = 1'b0;
            slv_err = 1'b0;
            wcnt    = 0;
            sbeat   = 0;
        end
    end

    // ---------------- bus / CPU monitor ----------------
    logic [WA-1:0] beat_adr [$];
    logic [2:0]    beat_cti [$];
    logic [1:0]    beat_bte [$];
    int            cyc_cycles = 0;
    int            unstable   = 0;
    int            consec     = 0;
    logic [WA-1:0] hold_adr;
    logic [2:0]    hold_cti;
    logic          hold_valid = 1'b0;
    logic          ack_prev   = 1'b0;

    always @(posedge wb_clk) begin
        if (bus.cyc) cyc_cycles++;
        if (bus.cyc && bus.stb && bus.ack) begin
            beat_adr.push_back(bus.adr);
            beat_cti.push_back(bus.cti);
            beat_bte.push_back(bus.bte);
        end
        if (hold_valid && bus.cyc && (bus.adr != hold_adr || bus.cti != hold_cti)) unstable++;
        hold_adr   = bus.adr;
        hold_cti   = bus.cti;
        hold_valid = bus.cyc && bus.stb && !bus.ack;
        if (cpu_ack_o && ack_prev) consec++;
        ack_prev = cpu_ack_o;
    end

    task automatic clear_log();
        beat_adr.delete();
        beat_cti.delete();
        beat_bte.delete();
        cyc_cycles = 0;
    endtask

    // Issue one request and wait (bounded) for the ack; lat counts posedges.
    task automatic fetch(input logic [WA-1:0] a, output logic [31:0] d, output int lat);
        @(negedge wb_clk);
        cpu_adr_i = a;
        cpu_req_i = 1'b1;
        lat = 0;
        while (lat < 200) begin
            @(posedge wb_clk);
            #1;
            lat++;
            if (cpu_ack_o) break;
        end
        d = cpu_dat_o;
        cpu_req_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && bus.cyc; i++) begin
            @(posedge wb_clk);
            #1;
        end
        @(posedge wb_clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        logic [WA-1:0] adr;
        int            waits;
        int            exp_lat;
        int            exp_beats;
        int            exp_cyc;
        logic [31:0]   exp_dat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] d;
        int          lat;

        vecs[0] = '{"hit w0",        22'h000, 0, 1, 0, 0,  32'hA940_0000};
        vecs[1] = '{"hit w3",        22'h003, 0, 1, 0, 0,  32'hA940_0003};
        vecs[2] = '{"hit w1",        22'h001, 0, 1, 0, 0,  32'hA940_0001};
        vecs[3] = '{"miss 3 waits",  22'h042, 3, 5, 4, 16, 32'hA940_0042};
        vecs[4] = '{"hit 041",       22'h041, 0, 1, 0, 0,  32'hA940_0041};
        vecs[5] = '{"hit 043",       22'h043, 0, 1, 0, 0,  32'hA940_0043};
        vecs[6] = '{"hit 040",       22'h040, 0, 1, 0, 0,  32'hA940_0040};

        wb_rst    = 1'b1;
        cpu_adr_i = '0;
        cpu_req_i = 1'b0;
        flush_i   = 1'b0;
        repeat (3) @(posedge wb_clk);
        #1;
        check("reset cpu ack/dat", {cpu_ack_o, cpu_dat_o}, 0);
        check("reset bus outputs", {bus.cyc, bus.stb, bus.cti, bus.bte, bus.adr}, 0);
`ifdef WB_FETCH_ERR_EN
        check("reset cpu_err", cpu_err_o, 0);
`endif
        @(negedge wb_clk);
        wb_rst = 1'b0;

        // ---- first miss, critical word 2, zero-wait slave ----
        waits = 0;
        clear_log();
        fetch(22'h002, d, lat);
        check("crit word data", d, 32'hA940_0002);
        check("crit word latency", lat, 2);
        wait_idle();
        check("burst beat count", beat_adr.size(), 4);
        if (beat_adr.size() == 4) begin
            check("burst adr seq", {beat_adr[0], beat_adr[1], beat_adr[2], beat_adr[3]},
                  {22'h002, 22'h003, 22'h000, 22'h001});
            check("burst cti seq", {beat_cti[0], beat_cti[1], beat_cti[2], beat_cti[3]},
                  {3'b010, 3'b010, 3'b010, 3'b111});
            check("burst bte seq", {beat_bte[0], beat_bte[1], beat_bte[2], beat_bte[3]},
                  {2'b01, 2'b01, 2'b01, 2'b01});
        end
        check("cyc cycles 0-wait", cyc_cycles, 4);
        check("bus idle after burst", {bus.cyc, bus.stb, bus.cti, bus.bte}, 0);

        // ---- table-driven hits and misses ----
        for (int i = 0; i < 7; i++) begin
            waits = vecs[i].waits;
            clear_log();
            unstable = 0;
            fetch(vecs[i].adr, d, lat);
            wait_idle();
            check({vecs[i].name, " data"}, d, vecs[i].exp_dat);
            check({vecs[i].name, " latency"}, lat, vecs[i].exp_lat);
            check({vecs[i].name, " beats"}, beat_adr.size(), vecs[i].exp_beats);
            check({vecs[i].name, " cyc cycles"}, cyc_cycles, vecs[i].exp_cyc);
            check({vecs[i].name, " wait stability"}, unstable, 0);
        end

        // ---- back-to-back hits: ack must leave a gap ----
        @(negedge wb_clk);
        cpu_adr_i = 22'h041;
        cpu_req_i = 1'b1;
        @(posedge wb_clk); #1;
        check("b2b first ack", {cpu_ack_o, cpu_dat_o}, {1'b1, 32'hA940_0041});
        cpu_adr_i = 22'h043;
        @(posedge wb_clk); #1;
        check("b2b gap", cpu_ack_o, 0);
        @(posedge wb_clk); #1;
        check("b2b second ack", {cpu_ack_o, cpu_dat_o}, {1'b1, 32'hA940_0043});
        cpu_req_i = 1'b0;
        @(posedge wb_clk); #1;

        // ---- same-line request while the burst is in flight ----
        waits = 0;
        clear_log();
        fetch(22'h002, d, lat);
        check("inflight crit latency", lat, 2);
        fetch(22'h001, d, lat);
        check("inflight word data", d, 32'hA940_0001);
        check("inflight word latency", lat, 3);
        check("inflight ack at burst end", bus.cyc, 0);
        wait_idle();
        check("inflight beats", beat_adr.size(), 4);

        // ---- foreign-line request stalls, then reburst ----
        clear_log();
        fetch(22'h042, d, lat);
        check("stall first crit", {lat[7:0], d}, {8'd2, 32'hA940_0042});
        fetch(22'h011, d, lat);
        check("stall data", d, 32'hA940_0011);
        check("stall latency", lat, 5);
        wait_idle();
        check("stall beats", beat_adr.size(), 8);
        if (beat_adr.size() == 8)
            check("stall second burst adr", {beat_adr[4], beat_adr[7]}, {22'h011, 22'h010});

        // ---- flush at beat 2 ----
        clear_log();
        @(negedge wb_clk);
        cpu_adr_i = 22'h002;
        cpu_req_i = 1'b1;
        @(posedge wb_clk); #1;
        @(posedge wb_clk); #1;
        check("flush crit ack", {cpu_ack_o, cpu_dat_o}, {1'b1, 32'hA940_0002});
        cpu_req_i = 1'b0;
        @(negedge wb_clk);
        flush_i = 1'b1;
        @(posedge wb_clk); #1;
        flush_i = 1'b0;
        wait_idle();
        check("flush burst beats", beat_adr.size(), 4);
        clear_log();
        fetch(22'h003, d, lat);
        wait_idle();
        check("after flush miss", {lat[7:0], d}, {8'd2, 32'hA940_0003});
        check("after flush reburst", beat_adr.size(), 4);

        // ---- flush in IDLE ----
        @(negedge wb_clk);
        flush_i = 1'b1;
        @(negedge wb_clk);
        flush_i = 1'b0;
        clear_log();
        fetch(22'h001, d, lat);
        wait_idle();
        check("idle flush miss", {lat[7:0], d}, {8'd2, 32'hA940_0001});
        check("idle flush reburst", beat_adr.size(), 4);

        // ---- reset mid-burst ----
        waits = 3;
        @(negedge wb_clk);
        cpu_adr_i = 22'h042;
        cpu_req_i = 1'b1;
        @(posedge wb_clk); #1;
        @(posedge wb_clk); #1;
        check("burst active before reset", {bus.cyc, bus.stb}, 2'b11);
        #2;
        wb_rst = 1'b1;
        #1;
        check("async reset bus", {bus.cyc, bus.stb, bus.cti, bus.bte, bus.adr}, 0);
        check("async reset cpu", {cpu_ack_o, cpu_dat_o}, 0);
        cpu_req_i = 1'b0;
        @(negedge wb_clk);
        wb_rst = 1'b0;
        waits = 0;
        clear_log();
        fetch(22'h002, d, lat);
        wait_idle();
        check("post reset miss", {lat[7:0], d}, {8'd2, 32'hA940_0002});
        check("post reset beats", beat_adr.size(), 4);

`ifdef WB_FETCH_ERR_EN
        // ---- bus error on the first beat ----
        err_beat = 0;
        clear_log();
        @(negedge wb_clk);
        cpu_adr_i = 22'h013;
        cpu_req_i = 1'b1;
        @(posedge wb_clk); #1;
        @(posedge wb_clk); #1;
        check("err cyc dropped", {bus.cyc, bus.stb, bus.cti, bus.bte}, 0);
        check("err strobe", {cpu_err_o, cpu_ack_o}, 2'b10);
        cpu_req_i = 1'b0;
        @(posedge wb_clk); #1;
        check("err strobe one cycle", {cpu_err_o, cpu_ack_o}, 2'b00);
        err_beat = -1;
        clear_log();
        fetch(22'h013, d, lat);
        wait_idle();
        check("after err miss", {lat[7:0], d}, {8'd2, 32'hA940_0013});
        check("after err reburst", beat_adr.size(), 4);
`endif

        check("no consecutive acks", consec, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
